// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit_if
//  Brief    : Prediction / resolution / redirect / training bundle shared by
//             the fetch predictor, the EX comparator and branch_resolve_unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if;
  // Fetch -> unit: prediction records
  logic        pred_valid;
  logic        pred_ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  // EX -> unit: actual outcome of the oldest in-flight branch
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  // Unit -> fetch: correction
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  // Unit -> predictor: training stream
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  // Sticky protocol error
  logic        orphan_err;

  // Resolve-unit side
  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready,
    output redirect_valid, redirect_pc, flush,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output orphan_err
  );

  // Pipeline side (fetch + EX)
  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready,
    input  redirect_valid, redirect_pc, flush,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  orphan_err
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit
//  Brief    : Queues fetch-stage predictions, checks each against the EX
//             outcome, raises flush + redirect on a mispredict and streams a
//             training update for every resolved branch.
//  Options  : define BRANCH_RESOLVE_STATS_EN to add saturating branch and
//             mispredict counters (stat_branches / stat_mispredicts).
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_unit_if.slave  bus
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0] FCNT_ONE   = FW'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [FW-1:0] flush_cnt;
  logic [FW-1:0] flush_cnt_nxt;
  logic          flush_out;

  // Prediction record storage
  logic [31:0]   pc_mem     [DEPTH];
  logic          taken_mem  [DEPTH];
  logic [31:0]   target_mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          in_idle;
  logic          not_empty;
  logic          ready;
  logic          do_pop;
  logic          do_push;
  logic          orphan;
  logic          mispredict;
  logic [31:0]   head_pc;
  logic          head_taken;
  logic [31:0]   head_target;
  logic [31:0]   correct_pc;

  // Registered outputs
  logic          redirect_valid_q;
  logic [31:0]   redirect_pc_q;
  logic          upd_valid_q;
  logic [31:0]   upd_pc_q;
  logic          upd_taken_q;
  logic [31:0]   upd_target_q;
  logic          orphan_err_q;

  // Decode the resolve against the head record and the push/pop handshakes
  always_comb begin
    in_idle     = (state == IDLE);
    not_empty   = (count != '0);
    head_pc     = pc_mem[rd_ptr];
    head_taken  = taken_mem[rd_ptr];
    head_target = target_mem[rd_ptr];

    // Resolves are ignored while flushing; with an empty queue they are orphans
    do_pop = bus.res_valid && in_idle && not_empty;
    orphan = bus.res_valid && in_idle && !not_empty;

    mispredict = do_pop &&
                 ((head_taken != bus.res_taken) ||
                  (head_taken && bus.res_taken && (head_target != bus.res_target)));

    correct_pc = bus.res_taken ? bus.res_target : (head_pc + 32'd4);

    // A pop in the same cycle frees a slot, so a full queue still accepts a
    // record while the oldest entry retires.
    ready   = in_idle && ((count < DEPTH_C) || do_pop);
    // A record pushed alongside a mispredicting pop is wrong-path: drop it
    do_push = bus.pred_valid && ready && !mispredict;
  end

  // Queue pointers and occupancy; a mispredict empties the whole queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mispredict) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Record storage; contents are qualified by count, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]     <= bus.pred_pc;
      taken_mem[wr_ptr]  <= bus.pred_taken;
      target_mem[wr_ptr] <= bus.pred_target;
    end
  end

  // Training, redirect and error outputs, one cycle after the resolve
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      upd_target_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      orphan_err_q     <= 1'b0;
    end else begin
      upd_valid_q      <= do_pop;
      redirect_valid_q <= mispredict;
      if (do_pop) begin
        upd_pc_q     <= head_pc;
        upd_taken_q  <= bus.res_taken;
        upd_target_q <= bus.res_target;
      end
      if (mispredict) begin
        redirect_pc_q <= correct_pc;
      end
      if (orphan) begin
        orphan_err_q <= 1'b1;
      end
    end
  end

  // Flush FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Flush FSM next state; flush is high for every cycle spent in FLUSH
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    flush_out     = 1'b0;
    case (state)
      IDLE: begin
        if (mispredict) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_INIT;
        end
      end
      FLUSH: begin
        flush_out = 1'b1;
        if (flush_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          flush_cnt_nxt = flush_cnt - FCNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  // Saturating resolve / mispredict counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (do_pop && (stat_branches != 32'hFFFF_FFFF)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

  assign bus.pred_ready     = ready;
  assign bus.flush          = flush_out;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_pc         = upd_pc_q;
  assign bus.upd_taken      = upd_taken_q;
  assign bus.upd_target     = upd_target_q;
  assign bus.orphan_err     = orphan_err_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_unit
//  Brief    : Self-checking bench for branch_resolve_unit with a reference
//             prediction queue and an expected-update scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_resolve_unit_if bus();

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_resolve_unit #(
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } rec_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic [31:0] rpc;
    int          due;
  } exp_t;

  rec_t mq[$];       // reference in-flight queue
  exp_t eq[$];       // expected update pulses
  int   flush_left = 0;
  exp_t mon_e;

  // Scoreboard monitor: every cycle either an expected update is due or no pulse may appear
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (eq.size() > 0 && eq[0].due <= cyc) begin
        mon_e = eq.pop_front();
        total++;
        if (bus.upd_valid !== 1'b1 || bus.upd_pc !== mon_e.pc ||
            bus.upd_taken !== mon_e.taken || bus.upd_target !== mon_e.target ||
            bus.redirect_valid !== mon_e.mis ||
            (mon_e.mis && bus.redirect_pc !== mon_e.rpc)) begin
          bad++;
          $display("FAIL update: got v=%0b pc=%h t=%0b tgt=%h rv=%0b rpc=%h want pc=%h t=%0b tgt=%h rv=%0b rpc=%h",
                   bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_target,
                   bus.redirect_valid, bus.redirect_pc,
                   mon_e.pc, mon_e.taken, mon_e.target, mon_e.mis, mon_e.rpc);
        end
      end else begin
        total++;
        if (bus.upd_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin
          bad++;
          $display("FAIL idle_pulse: got upd_valid=%0b redirect_valid=%0b want 0 0",
                   bus.upd_valid, bus.redirect_valid);
        end
      end
    end
  end

  // Drive one cycle of stimulus, advance the reference model, return ready seen vs expected
  task automatic drive_cycle(input logic pv, input logic [31:0] ppc, input logic pt,
                             input logic [31:0] ptg, input logic rv, input logic rt,
                             input logic [31:0] rtg, output logic rdy_dut, output logic rdy_exp);
    logic idle, pop, push, mis;
    rec_t h, r;
    exp_t e;
    bus.pred_valid  = pv;
    bus.pred_pc     = ppc;
    bus.pred_taken  = pt;
    bus.pred_target = ptg;
    bus.res_valid   = rv;
    bus.res_taken   = rt;
    bus.res_target  = rtg;
    #1;
    idle    = (flush_left == 0);
    pop     = rv && idle && (mq.size() > 0);
    rdy_exp = idle && ((mq.size() < DEPTH) || pop);
    rdy_dut = bus.pred_ready;
    push    = pv && rdy_exp;
    mis     = 1'b0;
    if (pop) begin
      h = mq.pop_front();
      mis = (h.taken != rt) || (h.taken && rt && (h.target != rtg));
      e.pc = h.pc; e.taken = rt; e.target = rtg; e.mis = mis;
      e.rpc = rt ? rtg : (h.pc + 32'd4);
      e.due = cyc + 1;
      eq.push_back(e);
    end
    if (flush_left > 0) flush_left--;
    if (mis) begin
      mq.delete();
      flush_left = FLUSH_CYCLES;
    end else if (push) begin
      r.pc = ppc; r.taken = pt; r.target = ptg;
      mq.push_back(r);
    end
    @(posedge clk);
    #1;
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.pred_taken = 1'b0; bus.pred_target = '0;
    bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.res_target = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.pred_ready !== 1'b1) begin bad++; $display("FAIL rst_pred_ready: got %b want 1", bus.pred_ready); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_redirect_valid: got %b want 0", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_redirect_pc: got %h want 0", bus.redirect_pc); end
    total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL rst_flush: got %b want 0", bus.flush); end
    total++; if (bus.upd_valid !== 1'b0) begin bad++; $display("FAIL rst_upd_valid: got %b want 0", bus.upd_valid); end
    total++; if (bus.upd_pc !== 32'h0 || bus.upd_taken !== 1'b0 || bus.upd_target !== 32'h0) begin
      bad++; $display("FAIL rst_upd_fields: got pc=%h t=%b tgt=%h want 0 0 0", bus.upd_pc, bus.upd_taken, bus.upd_target); end
    total++; if (bus.orphan_err !== 1'b0) begin bad++; $display("FAIL rst_orphan: got %b want 0", bus.orphan_err); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_correct_not_taken();
    logic rd, re;
    drive_cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rd, re);
    total++; if (rd !== re) begin bad++; $display("FAIL cnt_push_ready: got %b want %b", rd, re); end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, rd, re);
    #1;
    total++; if (bus.upd_pc !== 32'h100) begin bad++; $display("FAIL cnt_upd_pc: got %h want 00000100", bus.upd_pc); end
    total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL cnt_flush: got %b want 0", bus.flush); end
    total++; if (bus.pred_ready !== 1'b1 || mq.size() != 0) begin bad++; $display("FAIL cnt_empty_ready: got %b want 1", bus.pred_ready); end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rd, re);
  endtask

  task automatic test_direction_mispredict();
    logic rd, re;
    drive_cycle(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rd, re);
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h400, rd, re);
    #1;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL dir_flush1: got %b want 1", bus.flush); end
    total++; if (bus.redirect_pc !== 32'h400) begin bad++; $display("FAIL dir_redirect_pc: got %h want 00000400", bus.redirect_pc); end
    // push and resolve attempts during flush are both refused
    drive_cycle(1'b1, 32'h204, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, rd, re);
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL dir_ready_in_flush: got %b want 0", rd); end
    #1;
    total++; if (bus.flush !== 1'b1 || bus.pred_ready !== 1'b0) begin
      bad++; $display("FAIL dir_flush2: got flush=%b ready=%b want 1 0", bus.flush, bus.pred_ready); end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rd, re);
    #1;
    total++; if (bus.flush !== 1'b0 || bus.pred_ready !== 1'b1) begin
      bad++; $display("FAIL dir_flush_end: got flush=%b ready=%b want 0 1", bus.flush, bus.pred_ready); end
    total++; if (bus.orphan_err !== 1'b0) begin bad++; $display("FAIL dir_no_orphan: got %b want 0", bus.orphan_err); end
  endtask

  task automatic test_target_squash();
    logic rd, re;
    drive_cycle(1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, rd, re);
    drive_cycle(1'b1, 32'h304, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rd, re);
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h600, rd, re);
    #1;
    total++; if (bus.redirect_pc !== 32'h600) begin bad++; $display("FAIL tgt_redirect_pc: got %h want 00000600", bus.redirect_pc); end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rd, re);
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rd, re);
    // 0x304 was squashed, so this resolve finds the queue empty
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, rd, re);
    #1;
    total++; if (bus.orphan_err !== 1'b1) begin bad++; $display("FAIL tgt_orphan: got %b want 1", bus.orphan_err); end
  endtask

  task automatic test_wrap();
    logic rd, re;
    drive_cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, rd, re);
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1234, rd, re);
    #1;
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL wrap_redirect_pc: got %h want 00000000", bus.redirect_pc); end
    repeat (FLUSH_CYCLES) drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rd, re);
  endtask

  task automatic test_full_simul();
    logic rd, re;
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rd, re);
      total++; if (rd !== re) begin bad++; $display("FAIL full_push%0d_ready: got %b want %b", i, rd, re); end
    end
    #1;
    total++; if (bus.pred_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", bus.pred_ready); end
    drive_cycle(1'b1, 32'h1010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, rd, re);
    total++; if (rd !== 1'b1) begin bad++; $display("FAIL full_simul_ready: got %b want 1", rd); end
    #1;
    total++; if (bus.pred_ready !== 1'b0) begin bad++; $display("FAIL full_still_full: got %b want 0", bus.pred_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, rd, re);
    end
    #1;
    total++; if (bus.pred_ready !== 1'b1) begin bad++; $display("FAIL full_drained_ready: got %b want 1", bus.pred_ready); end
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rd, re);
  endtask

  task automatic test_reset_mid_flush();
    logic rd, re;
    drive_cycle(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rd, re);
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h800, rd, re);
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL rmf_flush_before: got %b want 1", bus.flush); end
    #1;
    reset = 1'b1;
    eq.delete();
    mq.delete();
    flush_left = 0;
    #1;
    total++; if (bus.flush !== 1'b0 || bus.pred_ready !== 1'b1) begin
      bad++; $display("FAIL rmf_flush_ready: got flush=%b ready=%b want 0 1", bus.flush, bus.pred_ready); end
    total++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0) begin
      bad++; $display("FAIL rmf_redirect: got v=%b pc=%h want 0 0", bus.redirect_valid, bus.redirect_pc); end
    total++; if (bus.upd_valid !== 1'b0 || bus.upd_pc !== 32'h0 || bus.upd_target !== 32'h0 || bus.upd_taken !== 1'b0) begin
      bad++; $display("FAIL rmf_upd: got v=%b pc=%h t=%b tgt=%h want zeros", bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_target); end
    total++; if (bus.orphan_err !== 1'b0) begin bad++; $display("FAIL rmf_orphan: got %b want 0", bus.orphan_err); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL rmf_after_release: got %b want 0", bus.flush); end
  endtask

  initial begin
    test_reset();
    test_correct_not_taken();
    test_direction_mispredict();
    test_target_squash();
    test_wrap();
    test_full_simul();
    test_reset_mid_flush();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (eq.size() != 0) begin
      bad++;
      $display("FAIL pending_updates: got %0d outstanding want 0", eq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
